alu_uart_sequencer: RTL and testbench



---
 rtl/alu_uart_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_uart_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_sequencer.sv
// Byte-serial front end for the alu: collects A, B, op from the UART receiver and sends the result byte back.
// Optional inter-byte timeout is enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_uart_sequencer #(
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned OP_SIZE        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  input  logic [DATA_SIZE-1:0] i_result,
  output logic [DATA_SIZE-1:0] o_a,
  output logic [DATA_SIZE-1:0] o_b,
  output logic [OP_SIZE-1:0]   o_op,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_timeout
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  state_t state;

  // Upper received bits beyond the operand/op widths are intentionally discarded.
  logic unused_rx_bits;
  assign unused_rx_bits = ^i_rx_data;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic             expired;
  assign expired = (count == CNT_MAX);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= WAIT_A;
      o_a        <= '0;
      o_b        <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      count      <= '0;
`endif
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      case (state)
        WAIT_A: begin
`ifdef ALU_SEQ_TIMEOUT_EN
          count <= '0;
`endif
          if (i_rx_done) begin
            o_a   <= i_rx_data[DATA_SIZE-1:0];
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (i_rx_done) begin
            o_b   <= i_rx_data[DATA_SIZE-1:0];
            state <= WAIT_OP;
`ifdef ALU_SEQ_TIMEOUT_EN
            count <= '0;
          end else if (expired) begin
            state     <= WAIT_A;
            o_timeout <= 1'b1;
            count     <= '0;
          end else begin
            count <= count + CNT_W'(1);
`endif
          end
        end
        WAIT_OP: begin
          if (i_rx_done) begin
            o_op   <= i_rx_data[OP_SIZE-1:0];
            o_busy <= 1'b1;
            state  <= SEND;
`ifdef ALU_SEQ_TIMEOUT_EN
            count  <= '0;
          end else if (expired) begin
            state     <= WAIT_A;
            o_timeout <= 1'b1;
            count     <= '0;
          end else begin
            count <= count + CNT_W'(1);
`endif
          end
        end
        // The ALU has settled on the operands registered last cycle.
        SEND: begin
          o_tx_data  <= 8'(i_result);
          o_tx_start <= 1'b1;
          state      <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= WAIT_A;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench for alu_uart_sequencer with a behavioural ALU model driving i_result.
// Define ALU_SEQ_TIMEOUT_EN to exercise the timeout path (TIMEOUT_CYCLES=16).
module tb_alu_uart_sequencer;

  localparam int unsigned DATA_SIZE = 8;
  localparam int unsigned OP_SIZE   = 6;
  localparam int unsigned TO_CYC    = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           rx_data;
  logic                 rx_done;
  logic                 tx_done;
  logic [DATA_SIZE-1:0] result;
  logic [DATA_SIZE-1:0] a_q;
  logic [DATA_SIZE-1:0] b_q;
  logic [OP_SIZE-1:0]   op_q;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 busy;
  logic                 timeout;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         timeout_seen = 0;
  bit         timeout_allowed = 1'b0;

  always #5 clk = ~clk;

  alu_uart_sequencer #(
    .DATA_SIZE(DATA_SIZE),
    .OP_SIZE(OP_SIZE),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_rx_data(rx_data),
    .i_rx_done(rx_done),
    .i_tx_done(tx_done),
    .i_result(result),
    .o_a(a_q),
    .o_b(b_q),
    .o_op(op_q),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .o_busy(busy),
    .o_timeout(timeout)
  );

  // Behavioural ALU: the same model serves as the datapath and as the reference.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic [7:0] r;
    case (op)
      6'h20: r = a + b;
      6'h22: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h02: r = a >> b;
      6'h03: r = 8'($signed(a) >>> b);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_comb result = alu_ref(a_q, b_q, op_q);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every transmit start, polices unexpected timeouts.
  always @(negedge clk) begin
    if (!reset && tx_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_start_unexpected: got data 0x%0h expected no start at %0t", tx_data, $time);
      end else begin
        chk("tx_data", int'(tx_data), int'(exp_q.pop_front()));
      end
    end
    if (!reset && timeout) begin
      if (timeout_allowed) timeout_seen++;
      else begin
        checks++;
        errors++;
        $display("FAIL timeout_unexpected: got 1 expected 0 at %0t", $time);
      end
    end
  end

  task automatic send_byte(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // Idle cycles with stray tx_done pulses, which must be ignored outside WAIT_TX.
  task automatic idle(input int n);
    repeat (n) begin
      tx_done = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      tx_done = 1'b0;
    end
  endtask

  task automatic finish_tx(input logic [7:0] a);
    int wait_n;
    wait_n = $urandom_range(0, 4);
    repeat (wait_n) begin
      if ($urandom_range(0, 1) == 1) begin
        rx_data = 8'h55;
        rx_done = 1'b1;
      end
      @(negedge clk);
      rx_done = 1'b0;
    end
    chk("a_hold_in_wait_tx", int'(a_q), int'(a));
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("busy_after_tx_done", int'(busy), 0);
  endtask

  task automatic send_op_and_finish(input logic [7:0] a, input logic [7:0] op);
    send_byte(op);
    chk("o_op", int'(op_q), int'(op[OP_SIZE-1:0]));
    chk("tx_start_in_send", int'(tx_start), 0);
    @(negedge clk);
    chk("tx_start_pulse", int'(tx_start), 1);
    chk("busy_during_tx", int'(busy), 1);
    @(negedge clk);
    chk("tx_start_one_cycle", int'(tx_start), 0);
    finish_tx(a);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int gap);
    exp_q.push_back(alu_ref(a, b, op[5:0]));
    send_byte(a);
    chk("o_a", int'(a_q), int'(a));
    idle(gap);
    send_byte(b);
    chk("o_b", int'(b_q), int'(b));
    idle(gap);
    send_op_and_finish(a, op);
  endtask

  task automatic chk_all_zero();
    chk("rst_a", int'(a_q), 0);
    chk("rst_b", int'(b_q), 0);
    chk("rst_op", int'(op_q), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout), 0);
  endtask

  initial begin
    logic [7:0] ops[9];
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03, 8'h3F};
    reset   = 1'b1;
    rx_done = 1'b0;
    tx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero();
    reset = 1'b0;

    // Directed vectors with hand-derived results.
    run_txn(8'h05, 8'h03, 8'h20, 0);
    chk("add_model", int'(alu_ref(8'h05, 8'h03, 6'h20)), 8'h08);
    run_txn(8'h03, 8'h05, 8'h22, 1);
    run_txn(8'h80, 8'h02, 8'h03, 0);
    run_txn(8'hF0, 8'h0F, 8'h27, 2);
    run_txn(8'h01, 8'h01, 8'h20, 0);

    // Reset after A and B, then reset racing an rx_done.
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    chk_all_zero();
    reset   = 1'b1;
    rx_data = 8'h11;
    rx_done = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    rx_done = 1'b0;
    chk("rst_wins_over_rx", int'(a_q), 0);
    run_txn(8'h02, 8'h03, 8'h24, 0);

`ifdef ALU_SEQ_TIMEOUT_EN
    send_byte(8'h07);
    timeout_allowed = 1'b1;
    repeat (TO_CYC + 8) @(negedge clk);
    timeout_allowed = 1'b0;
    chk("timeout_pulses", timeout_seen, 1);
    chk("a_kept_after_timeout", int'(a_q), 8'h07);
    run_txn(8'h07, 8'h01, 8'h20, 0);
`else
    exp_q.push_back(alu_ref(8'h09, 8'h04, 6'h22));
    send_byte(8'h09);
    send_byte(8'h04);
    repeat (1000) @(negedge clk);
    chk("no_timeout_idle", timeout_seen, 0);
    chk("b_held_idle", int'(b_q), 8'h04);
    send_op_and_finish(8'h09, 8'h22);
`endif

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 7) == 0) op = 8'($urandom);
      run_txn(8'($urandom), 8'($urandom), op, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
